// File: rtl/ramb_pkg.sv
// rtl/ramb_pkg.sv - shared types and sizing helper for the parametrised RAM bank
package ramb_pkg;

  typedef enum logic [1:0] {
    RDW_NO_CHANGE,
    RDW_WRITE_FIRST,
    RDW_READ_FIRST
  } rdw_mode_t;

  typedef enum logic {
    CLEAR,
    IDLE
  } ramb_state_t;

  // Bits needed to index 'value' entries; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ramb_clr_seq.sv
// rtl/ramb_clr_seq.sv - zero-fill sequencer: walks every word once after reset or on request
module ramb_clr_seq
  import ramb_pkg::*;
#(
  parameter int DEPTH          = 128,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int CNT_W          = 7
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr_req,
  output logic [CNT_W-1:0] o_clr_addr,
  output logic             o_clr_we,
  output logic             o_busy
);

  localparam ramb_state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

  ramb_state_t      r_state;
  ramb_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_clr_we    = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      CLEAR: begin
        o_clr_we = 1'b1;
        o_busy   = 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/ramb_sp_param.sv
// rtl/ramb_sp_param.sv - single-port RAM bank with RDW mode, optional output register and clear
module ramb_sp_param
  import ramb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 7,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    DEPTH          = 128,
  parameter rdw_mode_t             RDW_MODE       = RDW_NO_CHANGE,
  parameter int                    OUT_REG        = 0,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE      = '0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  cs,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] wordAddr,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  clrReq,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  busy
);

  localparam int CNT_W = clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [CNT_W-1:0]      w_clr_addr;
  logic                  w_clr_we;
  logic                  w_busy;
  logic                  w_acc;
  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] r_d1;
  logic                  r_v1;

  ramb_clr_seq #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .CNT_W          (CNT_W)
  ) u_clr_seq (
    .i_clk      (clk),
    .i_rstn     (rstN),
    .i_clr_req  (clrReq),
    .o_clr_addr (w_clr_addr),
    .o_clr_we   (w_clr_we),
    .o_busy     (w_busy)
  );

  // clrReq wins over a same-cycle access; nothing is accepted while clearing
  assign w_acc      = cs && !w_busy && !clrReq;
  assign w_in_range = {1'b0, wordAddr} < DEPTH_W;
  assign w_rd_word  = w_in_range ? r_mem[wordAddr] : '0;
  assign busy       = w_busy;

  always_ff @(posedge clk) begin
    if (w_clr_we && rstN) begin
      r_mem[w_clr_addr] <= CLR_VALUE;
    end else if (w_acc && wr && w_in_range) begin
      r_mem[wordAddr] <= dataIn;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_d1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= 1'b0;
      if (w_acc) begin
        if (!wr) begin
          r_d1 <= w_rd_word;
          r_v1 <= 1'b1;
        end else if (RDW_MODE == RDW_WRITE_FIRST) begin
          r_d1 <= w_in_range ? dataIn : '0;
          r_v1 <= 1'b1;
        end else if (RDW_MODE == RDW_READ_FIRST) begin
          r_d1 <= w_rd_word;
          r_v1 <= 1'b1;
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_d2;
    logic                  r_v2;

    // second stage keeps shifting during a clear so in-flight reads still emerge
    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        r_d2 <= '0;
        r_v2 <= 1'b0;
      end else begin
        r_d2 <= r_d1;
        r_v2 <= r_v1;
      end
    end

    assign dataOut   = r_d2;
    assign dataValid = r_v2;
  end else begin : g_no_out_reg
    assign dataOut   = r_d1;
    assign dataValid = r_v1;
  end

endmodule
